// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared types and limits for the staged reset sequencer.
//   rst_state_e : sequencer FSM state encoding
//   MAX_DOMAINS : upper bound on the number of reset domains
// Optional feature macro: RST_SEQ_SOFT_RST_EN adds the StSoft state.
package rst_seq_pkg;

    localparam int unsigned MAX_DOMAINS = 8;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
`ifdef RST_SEQ_SOFT_RST_EN
        StRun     = 2'd2,
        StSoft    = 2'd3
`else
        StRun     = 2'd2
`endif
    } rst_state_e;

endpackage

// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: bundle of the sequencer's domain-facing signals.
//   sub_rst_n    : per-domain active-low resets (bit 0 released first)
//   ready        : high once every domain is released
//   soft_rst_req : level request to restart the sequence  (RST_SEQ_SOFT_RST_EN only)
//   soft_rst_ack : one-cycle pulse when a request is taken (RST_SEQ_SOFT_RST_EN only)
// Modports: master = the sequencer, slave = the consumer of the resets.
interface rst_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 3
);

    logic [NUM_DOMAINS-1:0] sub_rst_n;
    logic                   ready;

`ifdef RST_SEQ_SOFT_RST_EN
    logic soft_rst_req;
    logic soft_rst_ack;

    modport master (
        output sub_rst_n,
        output ready,
        input  soft_rst_req,
        output soft_rst_ack
    );

    modport slave (
        input  sub_rst_n,
        input  ready,
        output soft_rst_req,
        input  soft_rst_ack
    );
`else
    modport master (
        output sub_rst_n,
        output ready
    );

    modport slave (
        input  sub_rst_n,
        input  ready
    );
`endif

endinterface

// File: rtl/rst_seq_timer.sv
// rst_seq_timer: clearable up-counter with terminal-count compare.
//   clk, rst_n : clock, async active-low reset (count clears)
//   clr        : synchronous clear, wins over en
//   en         : count enable
//   last       : terminal value; tc is high while enabled and count == last
//   tc         : terminal count reached this cycle
module rst_seq_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] last,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc = en && (count_q == last);

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: releases one active-low reset per domain in a fixed, staggered
// order after a hold-off period following rst_n deassertion.
//   clk   : system clock
//   rst_n : async active-low reset from the global reset synchronizer
//   bus   : rst_sequencer_if.master (sub_rst_n, ready, optional soft reset pair)
// Parameters: NUM_DOMAINS (1..8), HOLD_CYCLES (>=1), STAGGER_CYCLES (>=1).
// Optional feature macro: RST_SEQ_SOFT_RST_EN enables the soft-reset request/ack
// and the StSoft state; without it StRun is terminal until rst_n asserts.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS    = 3,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4
) (
    input logic               clk,
    input logic               rst_n,
    rst_sequencer_if.master   bus
);

    localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES
                                                                     : STAGGER_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned IDX_W   = $clog2(MAX_DOMAINS + 1);

    // Timer compares against count == N-1 so the event lands on edge N.
    localparam logic [CNT_W-1:0]       HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]       STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]       DONE_IDX     = IDX_W'(NUM_DOMAINS);
    localparam logic [NUM_DOMAINS-1:0] DOM_ONE      = NUM_DOMAINS'(1);

    rst_state_e             state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_DOMAINS-1:0] sub_q;
    logic                   ready_q;

    logic             timer_clr;
    logic             timer_en;
    logic [CNT_W-1:0] timer_last;
    logic             timer_tc;

    always_comb begin
        timer_en   = (state_q == StHold) || (state_q == StRelease);
        timer_last = (state_q == StHold) ? HOLD_LAST : STAGGER_LAST;
        // Restart on every terminal count; hold at zero outside counting states.
        timer_clr  = timer_tc || !timer_en;
    end

    rst_seq_timer #(
        .WIDTH (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (timer_clr),
        .en    (timer_en),
        .last  (timer_last),
        .tc    (timer_tc)
    );

`ifdef RST_SEQ_SOFT_RST_EN
    logic ack_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StHold;
            idx_q   <= '0;
            sub_q   <= '0;
            ready_q <= 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
            ack_q   <= 1'b0;
`endif
        end else begin
`ifdef RST_SEQ_SOFT_RST_EN
            ack_q <= 1'b0;
`endif
            case (state_q)
                StHold: begin
                    if (timer_tc) begin
                        sub_q   <= DOM_ONE;
                        idx_q   <= IDX_W'(1);
                        state_q <= StRelease;
                    end
                end
                StRelease: begin
                    // Check completion first so the edge after the last release goes to RUN.
                    if (idx_q == DONE_IDX) begin
                        ready_q <= 1'b1;
                        state_q <= StRun;
                    end else if (timer_tc) begin
                        sub_q <= sub_q | (DOM_ONE << idx_q);
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StRun: begin
`ifdef RST_SEQ_SOFT_RST_EN
                    if (bus.soft_rst_req) begin
                        sub_q   <= '0;
                        ready_q <= 1'b0;
                        idx_q   <= '0;
                        ack_q   <= 1'b1;
                        state_q <= StSoft;
                    end
`endif
                end
`ifdef RST_SEQ_SOFT_RST_EN
                StSoft: begin
                    state_q <= StHold;
                end
`endif
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

    assign bus.sub_rst_n = sub_q;
    assign bus.ready     = ready_q;
`ifdef RST_SEQ_SOFT_RST_EN
    assign bus.soft_rst_ack = ack_q;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: self-checking bench for rst_sequencer.
// dut0 uses the default parameters; dut1 uses NUM_DOMAINS=1, HOLD_CYCLES=1.
// Soft-reset scenarios are built only when RST_SEQ_SOFT_RST_EN is defined.
module tb_rst_sequencer;

    localparam int unsigned N0 = 3;
    localparam int unsigned H0 = 16;
    localparam int unsigned S0 = 4;
    // Edge (relative to sequence start) after which ready is high.
    localparam int          R0 = H0 + (N0 - 1) * S0 + 1;
`ifdef RST_SEQ_SOFT_RST_EN
    localparam bit SOFT_ON = 1'b1;
`else
    localparam bit SOFT_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n0;
    logic rst_n1;

    always #5 clk = ~clk;

    rst_sequencer_if #(.NUM_DOMAINS(N0)) bus0 ();
    rst_sequencer_if #(.NUM_DOMAINS(1))  bus1 ();

    rst_sequencer #(
        .NUM_DOMAINS    (N0),
        .HOLD_CYCLES    (H0),
        .STAGGER_CYCLES (S0)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n0),
        .bus   (bus0)
    );

    rst_sequencer #(
        .NUM_DOMAINS    (1),
        .HOLD_CYCLES    (1),
        .STAGGER_CYCLES (4)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n1),
        .bus   (bus1)
    );

    typedef struct packed {
        logic [N0-1:0] sub;
        logic          rdy;
        logic          ack;
    } exp_t;

    typedef struct packed {
        logic sub;
        logic rdy;
    } exp1_t;

    exp_t  sb[$];
    exp1_t sb1[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model for dut0, expressed in terms of the release schedule.
    int edge_cnt;
    int base;
    bit soft_pending;
    int exp_acks;

    function automatic logic [N0-1:0] sched_sub(input int c);
        logic [N0-1:0] v;
        v = '0;
        for (int k = 0; k < N0; k++) begin
            if (c >= H0 + k * S0) v[k] = 1'b1;
        end
        return v;
    endfunction

    task automatic model_reset();
        edge_cnt     = 0;
        base         = 0;
        soft_pending = 1'b0;
        exp_acks     = 0;
        sb.delete();
    endtask

    // Drive one cycle of stimulus into dut0 and push the expected outcome.
    task automatic drive_edge(input logic req);
        exp_t e;
        int   c;
`ifdef RST_SEQ_SOFT_RST_EN
        bus0.soft_rst_req = req;
`endif
        edge_cnt++;
        c = edge_cnt - base;
        if (soft_pending) begin
            e            = '{sub: '0, rdy: 1'b0, ack: 1'b0};
            base         = edge_cnt;
            soft_pending = 1'b0;
        end else if (SOFT_ON && req && c >= R0 + 1) begin
            e            = '{sub: '0, rdy: 1'b0, ack: 1'b1};
            soft_pending = 1'b1;
            exp_acks++;
        end else begin
            e = '{sub: sched_sub(c), rdy: (c >= R0), ack: 1'b0};
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus0.sub_rst_n !== 3'b000) begin
            n_fail++;
            $display("FAIL reset sub_rst_n: got %b want 000", bus0.sub_rst_n);
        end
        n_checks++;
        if (bus0.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset ready: got %b want 0", bus0.ready);
        end
`ifdef RST_SEQ_SOFT_RST_EN
        n_checks++;
        if (bus0.soft_rst_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset soft_rst_ack: got %b want 0", bus0.soft_rst_ack);
        end
`endif
        n_checks++;
        if (bus1.sub_rst_n !== 1'b0 || bus1.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset dut1: got sub=%b ready=%b want 0/0", bus1.sub_rst_n,
                     bus1.ready);
        end
    endtask

    task automatic test_schedule();
        exp_t e;
        rst_n0 = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) begin
            drive_edge(1'b0);
            e = sb.pop_front();
            n_checks++;
            if (bus0.sub_rst_n !== e.sub) begin
                n_fail++;
                $display("FAIL schedule sub_rst_n edge %0d: got %b want %b", edge_cnt,
                         bus0.sub_rst_n, e.sub);
            end
            n_checks++;
            if (bus0.ready !== e.rdy) begin
                n_fail++;
                $display("FAIL schedule ready edge %0d: got %b want %b", edge_cnt,
                         bus0.ready, e.rdy);
            end
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        rst_n0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n0 = 1'b1;
        model_reset();
        for (int i = 0; i < 48; i++) begin
            if (i == 18) begin
                // Assert reset between edges; outputs must clear with no clock edge.
                #2 rst_n0 = 1'b0;
                #1;
                n_checks++;
                if (bus0.sub_rst_n !== 3'b000 || bus0.ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL mid_reset async: got sub=%b ready=%b want 000/0",
                             bus0.sub_rst_n, bus0.ready);
                end
                @(posedge clk);
                #1;
                rst_n0 = 1'b1;
                model_reset();
            end
            drive_edge(1'b0);
            e = sb.pop_front();
            n_checks++;
            if (bus0.sub_rst_n !== e.sub || bus0.ready !== e.rdy) begin
                n_fail++;
                $display("FAIL mid_reset edge %0d: got sub=%b ready=%b want sub=%b ready=%b",
                         edge_cnt, bus0.sub_rst_n, bus0.ready, e.sub, e.rdy);
            end
        end
    endtask

`ifdef RST_SEQ_SOFT_RST_EN
    task automatic test_soft_pulse();
        exp_t e;
        int   acks;
        acks = 0;
        exp_acks = 0;
        for (int i = 0; i < 31; i++) begin
            drive_edge(i == 0);
            e = sb.pop_front();
            if (bus0.soft_rst_ack === 1'b1) acks++;
            n_checks++;
            if (bus0.sub_rst_n !== e.sub || bus0.ready !== e.rdy ||
                bus0.soft_rst_ack !== e.ack) begin
                n_fail++;
                $display("FAIL soft_pulse edge %0d: got sub=%b rdy=%b ack=%b want %b/%b/%b",
                         edge_cnt, bus0.sub_rst_n, bus0.ready, bus0.soft_rst_ack,
                         e.sub, e.rdy, e.ack);
            end
        end
        n_checks++;
        if (acks != 1) begin
            n_fail++;
            $display("FAIL soft_pulse ack count: got %0d want 1", acks);
        end
    endtask

    task automatic test_soft_in_release();
        exp_t e;
        rst_n0 = 1'b0;
        @(posedge clk);
        #1;
        rst_n0 = 1'b1;
        model_reset();
        for (int i = 1; i <= 30; i++) begin
            drive_edge(i == 21);
            e = sb.pop_front();
            n_checks++;
            if (bus0.sub_rst_n !== e.sub || bus0.ready !== e.rdy ||
                bus0.soft_rst_ack !== e.ack) begin
                n_fail++;
                $display("FAIL soft_in_release edge %0d: got %b/%b/%b want %b/%b/%b",
                         edge_cnt, bus0.sub_rst_n, bus0.ready, bus0.soft_rst_ack,
                         e.sub, e.rdy, e.ack);
            end
        end
    endtask

    task automatic test_soft_held();
        exp_t e;
        int   acks;
        logic prev_ack;
        acks     = 0;
        prev_ack = 1'b0;
        exp_acks = 0;
        for (int i = 0; i < 60; i++) begin
            drive_edge(1'b1);
            e = sb.pop_front();
            if (bus0.soft_rst_ack === 1'b1) acks++;
            n_checks++;
            if (bus0.sub_rst_n !== e.sub || bus0.ready !== e.rdy ||
                bus0.soft_rst_ack !== e.ack) begin
                n_fail++;
                $display("FAIL soft_held edge %0d: got %b/%b/%b want %b/%b/%b",
                         edge_cnt, bus0.sub_rst_n, bus0.ready, bus0.soft_rst_ack,
                         e.sub, e.rdy, e.ack);
            end
            n_checks++;
            if (prev_ack === 1'b1 && bus0.soft_rst_ack === 1'b1) begin
                n_fail++;
                $display("FAIL soft_held back_to_back ack at edge %0d: got 1 want 0",
                         edge_cnt);
            end
            prev_ack = bus0.soft_rst_ack;
        end
        n_checks++;
        if (acks != exp_acks || acks != 3) begin
            n_fail++;
            $display("FAIL soft_held ack count: got %0d want 3", acks);
        end
        bus0.soft_rst_req = 1'b0;
    endtask
`endif

    task automatic test_one_domain();
        exp1_t e;
        rst_n1 = 1'b0;
        @(posedge clk);
        #1;
        rst_n1 = 1'b1;
        sb1.delete();
        for (int i = 1; i <= 5; i++) begin
            sb1.push_back('{sub: (i >= 1), rdy: (i >= 2)});
            @(posedge clk);
            #1;
            e = sb1.pop_front();
            n_checks++;
            if (bus1.sub_rst_n !== e.sub || bus1.ready !== e.rdy) begin
                n_fail++;
                $display("FAIL one_domain edge %0d: got sub=%b ready=%b want %b/%b", i,
                         bus1.sub_rst_n, bus1.ready, e.sub, e.rdy);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n0 = 1'b0;
        rst_n1 = 1'b0;
`ifdef RST_SEQ_SOFT_RST_EN
        bus0.soft_rst_req = 1'b0;
        bus1.soft_rst_req = 1'b0;
`endif
        test_reset();
        test_schedule();
        test_mid_reset();
`ifdef RST_SEQ_SOFT_RST_EN
        test_soft_pulse();
        test_soft_in_release();
        test_soft_held();
`endif
        test_one_domain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Staged reset release stage sitting directly downstream of the push-button reset synchronizer. It takes the synchronized global reset `rst_n` and produces one active-low reset per subsystem domain, released in a fixed, staggered order after a hold-off period. It also accepts an optional synchronous soft-reset request that restarts the sequence.

## Interface
- `NUM_DOMAINS`, default 3: number of downstream reset domains (1..8).
- `HOLD_CYCLES`, default 16: cycles after `rst_n` deassertion before domain 0 is released (>=1).
- `STAGGER_CYCLES`, default 4: cycles between consecutive domain releases (>=1).

Ports:
- `clk`  in  1: system clock, all state on posedge.
- `rst_n`  in  1: asynchronous, active-low reset, driven by the global reset synchronizer. Asserts immediately, deasserts synchronously to the upstream stage.
- `soft_rst_req`  in  1: synchronous level request for a sequence restart. Present only with `SOFT_RST_EN`.
- `soft_rst_ack`  out  1: one-cycle pulse when a soft request is accepted.
- `sub_rst_n`  out  NUM_DOMAINS: per-domain active-low resets. Bit 0 is released first.
- `ready`  out  1: high once every domain is released.

## Operation
- States: HOLD, RELEASE, RUN, plus SOFT when `SOFT_RST_EN` is defined.
- `rst_n` low, asynchronously:
  - state goes to HOLD and the counter clears;
  - `sub_rst_n` = all 0, `ready` = 0, `soft_rst_ack` = 0.
- HOLD:
  - the counter increments on every posedge;
  - when the count reaches HOLD_CYCLES, `sub_rst_n[0]` goes to 1, the state moves to RELEASE and the counter clears.
- RELEASE:
  - the counter increments each edge;
  - on reaching STAGGER_CYCLES, the next domain bit goes to 1 and the counter clears;
  - the edge after the last bit is set moves the state to RUN with `ready` = 1.
  - With NUM_DOMAINS = 1, RELEASE lasts one edge, then RUN.
- RUN: outputs are held and the counter is idle.
- Released `sub_rst_n` bits never drop, except on `rst_n` low or an accepted soft reset.
- Counter width is $clog2(max(HOLD_CYCLES, STAGGER_CYCLES)+1). The counter must not overflow.

## Timing
- Cycle 1 is the first posedge sampling `rst_n` high.
- `sub_rst_n[k]` rises after posedge HOLD_CYCLES + k·STAGGER_CYCLES.
- `ready` rises after posedge HOLD_CYCLES + (NUM_DOMAINS−1)·STAGGER_CYCLES + 1.
- Soft request, sampled high on a posedge in RUN:
  - on that same edge, all `sub_rst_n` go to 0, `ready` goes to 0, `soft_rst_ack` goes to 1 for one cycle, and the state moves to SOFT;
  - the next edge moves to HOLD with the counter cleared;
  - the release schedule then repeats, with cycle 1 being the first edge in HOLD.
- `soft_rst_req` is ignored in HOLD, RELEASE and SOFT. No ack is issued and there is no queueing.
- A request still high on re-entering RUN is accepted again. Requesters drop the request on the ack.
- `rst_n` low mid-sequence or mid-soft-reset overrides everything immediately and returns all outputs to their reset values.

## Configuration
- `RST_SEQ_SOFT_RST_EN`:
  - Defined: the `soft_rst_req`/`soft_rst_ack` ports and the SOFT state exist, behaving as above.
  - Undefined: both ports and the SOFT state are absent. RUN is terminal until `rst_n` is asserted.

## Structure
- Package `rst_seq_pkg` holds:
  - the state enum typedef (HOLD, RELEASE, RUN, SOFT);
  - the `NUM_DOMAINS` upper bound constant (8).
- One sub-module is natural: `rst_seq_timer`, a clearable up-counter with terminal-count compare, instantiated once and shared by HOLD and RELEASE.
- A domain index register tracks the next bit to release.

## Test plan
- Defaults; deassert `rst_n` -> `sub_rst_n` 000→001 after edge 16, 011 after edge 20, 111 after edge 24; `ready` = 1 after edge 25.
- Assert `rst_n` low at cycle 18 (between releases) -> all outputs 0 asynchronously. Deassert -> full schedule restarts from cycle 1.
- `RST_SEQ_SOFT_RST_EN`, RUN, one-cycle `soft_rst_req` -> `soft_rst_ack` pulses once, `sub_rst_n` = 000 and `ready` = 0 on the same edge, then 001 sixteen edges after HOLD entry.
- Soft request pulsed during RELEASE (cycle 21) -> no ack and no change to the schedule.
- `soft_rst_req` held high continuously -> ack repeats once per completed sequence (every 27 edges with defaults), never twice back-to-back.
- NUM_DOMAINS = 1, HOLD_CYCLES = 1 -> `sub_rst_n[0]` = 1 after edge 1 and `ready` = 1 after edge 2.
